// File: rtl/forwarding_hazard_unit.sv
// Operand-forwarding and load-use hazard unit for the 5-stage pipeline.
// Selects ALU and store-data bypass sources and stalls/bubbles the front end on load-use.
module forwarding_hazard_unit #(
  parameter int INST_W     = 19,
  parameter int RA_W       = 3,
  parameter int DST_LSB    = 11,
  parameter int SRC1_LSB   = 8,
  parameter int SRC2_LSB   = 5,
  parameter int LOAD_STALL = 1,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [INST_W-1:0] ID_inst,
  input  logic              ID_valid,
  input  logic              ID_reg2_read_source,
  input  logic [INST_W-1:0] EX_inst,
  input  logic              EX_reg_write_signal,
  input  logic              EX_mem_read,
  input  logic              EX_mem_write,
  input  logic [INST_W-1:0] MEM_inst,
  input  logic              MEM_reg_write_signal,
  input  logic [INST_W-1:0] WB_inst,
  input  logic              WB_reg_write_signal,
  output logic [1:0]        forward_A,
  output logic [1:0]        forward_B,
  output logic              forward_mem_data,
  output logic              stall,
  output logic              bubble,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  fwd_count
);

  typedef enum logic {IDLE, HOLD} state_t;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_EX  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;
  localparam logic [1:0] SEL_WB  = 2'b11;

  state_t          state;
  logic [2:0]      cnt;
  logic [RA_W-1:0] d_ex, d_mem, d_wb, s1, s2, s_b;
  logic            load_use;

  assign d_ex  = EX_inst[DST_LSB +: RA_W];
  assign d_mem = MEM_inst[DST_LSB +: RA_W];
  assign d_wb  = WB_inst[DST_LSB +: RA_W];
  assign s1    = ID_inst[SRC1_LSB +: RA_W];
  assign s2    = ID_inst[SRC2_LSB +: RA_W];
  assign s_b   = ID_reg2_read_source ? s1 : s2;

  // Only the instruction fields above are consumed; the rest of each word is don't-care here.
  logic unused_inst_bits;
  assign unused_inst_bits = ^{ID_inst, EX_inst, MEM_inst, WB_inst};

  // Register 0 is hard-wired zero, so a write to it is never a real producer.
  function automatic logic stage_match(input logic we, input logic [RA_W-1:0] d,
                                       input logic [RA_W-1:0] s);
    return we && (d != '0) && (d == s);
  endfunction

  // A load in EX has no result yet, so it is skipped and older stages are considered.
  function automatic logic [1:0] pick_source(input logic [RA_W-1:0] s);
    if (stage_match(EX_reg_write_signal, d_ex, s) && !EX_mem_read) return SEL_EX;
    if (stage_match(MEM_reg_write_signal, d_mem, s))                return SEL_MEM;
    if (stage_match(WB_reg_write_signal, d_wb, s))                  return SEL_WB;
    return SEL_RF;
  endfunction

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    forward_A        = SEL_RF;
    forward_B        = SEL_RF;
    forward_mem_data = 1'b0;
    if (!rst) begin
      forward_A        = pick_source(s1);
      forward_B        = pick_source(s_b);
      forward_mem_data = EX_mem_write && stage_match(MEM_reg_write_signal, d_mem, d_ex);
    end
  end

  assign load_use = ID_valid && EX_mem_read && EX_reg_write_signal && (d_ex != '0) &&
                    ((d_ex == s1) || (d_ex == s_b));

  // IDLE asserts the first bubble combinationally; HOLD supplies the remaining LOAD_STALL-1.
  assign stall  = !rst && ((state == HOLD) || load_use);
  assign bubble = stall;

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load_use && (LOAD_STALL > 1)) begin
            state <= HOLD;
            cnt   <= 3'(LOAD_STALL - 1);
          end
        end
        HOLD: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
      fwd_count   <= '0;
    end else begin
      if (stall && (stall_count != '1))
        stall_count <= stall_count + 1'b1;
      if (ID_valid && !stall && ((forward_A != SEL_RF) || (forward_B != SEL_RF)) &&
          (fwd_count != '1))
        fwd_count <= fwd_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Directed bench for forwarding_hazard_unit: one instance with LOAD_STALL=1, one with LOAD_STALL=3,
// sharing the same pipeline stimulus.
module tb_forwarding_hazard_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [18:0] ID_inst, EX_inst, MEM_inst, WB_inst;
  logic        ID_valid, ID_reg2_read_source;
  logic        EX_reg_write_signal, EX_mem_read, EX_mem_write;
  logic        MEM_reg_write_signal, WB_reg_write_signal;

  logic [1:0]  fa1, fb1, fa3, fb3;
  logic        fmd1, fmd3, stall1, stall3, bubble1, bubble3;
  logic [15:0] sc1, sc3, fc1, fc3;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  forwarding_hazard_unit #(.LOAD_STALL(1)) u1 (
    .clk(clk), .rst(rst),
    .ID_inst(ID_inst), .ID_valid(ID_valid), .ID_reg2_read_source(ID_reg2_read_source),
    .EX_inst(EX_inst), .EX_reg_write_signal(EX_reg_write_signal),
    .EX_mem_read(EX_mem_read), .EX_mem_write(EX_mem_write),
    .MEM_inst(MEM_inst), .MEM_reg_write_signal(MEM_reg_write_signal),
    .WB_inst(WB_inst), .WB_reg_write_signal(WB_reg_write_signal),
    .forward_A(fa1), .forward_B(fb1), .forward_mem_data(fmd1),
    .stall(stall1), .bubble(bubble1), .stall_count(sc1), .fwd_count(fc1)
  );

  forwarding_hazard_unit #(.LOAD_STALL(3)) u3 (
    .clk(clk), .rst(rst),
    .ID_inst(ID_inst), .ID_valid(ID_valid), .ID_reg2_read_source(ID_reg2_read_source),
    .EX_inst(EX_inst), .EX_reg_write_signal(EX_reg_write_signal),
    .EX_mem_read(EX_mem_read), .EX_mem_write(EX_mem_write),
    .MEM_inst(MEM_inst), .MEM_reg_write_signal(MEM_reg_write_signal),
    .WB_inst(WB_inst), .WB_reg_write_signal(WB_reg_write_signal),
    .forward_A(fa3), .forward_B(fb3), .forward_mem_data(fmd3),
    .stall(stall3), .bubble(bubble3), .stall_count(sc3), .fwd_count(fc3)
  );

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // dst in [13:11], src1 in [10:8], src2 in [7:5]
  function automatic logic [18:0] mk(input logic [2:0] d, input logic [2:0] a, input logic [2:0] b);
    logic [18:0] r;
    r        = '0;
    r[13:11] = d;
    r[10:8]  = a;
    r[7:5]   = b;
    return r;
  endfunction

  task automatic clear_inputs();
    ID_inst = '0; EX_inst = '0; MEM_inst = '0; WB_inst = '0;
    ID_valid = 1'b0; ID_reg2_read_source = 1'b0;
    EX_reg_write_signal = 1'b0; EX_mem_read = 1'b0; EX_mem_write = 1'b0;
    MEM_reg_write_signal = 1'b0; WB_reg_write_signal = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    #1;
  endtask

  task automatic set_load_use();
    clear_inputs();
    EX_inst = mk(3'd6, 3'd0, 3'd0); EX_reg_write_signal = 1'b1; EX_mem_read = 1'b1;
    ID_inst = mk(3'd1, 3'd6, 3'd2); ID_valid = 1'b1;
  endtask

  // Stage after the load has advanced: bubble in EX, the load now in MEM.
  task automatic set_after_load();
    clear_inputs();
    MEM_inst = mk(3'd6, 3'd0, 3'd0); MEM_reg_write_signal = 1'b1;
    ID_inst  = mk(3'd1, 3'd6, 3'd2); ID_valid = 1'b1;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    // Outputs held at zero while reset is asserted, even with a forwarding pattern present.
    EX_inst = mk(3'd3, 3'd0, 3'd0); EX_reg_write_signal = 1'b1;
    ID_inst = mk(3'd4, 3'd3, 3'd3); ID_valid = 1'b1;
    #2;
    check("rst_fwdA", 32'(fa1), 32'd0);
    check("rst_stall", 32'(stall3), 32'd0);
    check("rst_sc", 32'(sc1), 32'd0);
    check("rst_fc", 32'(fc3), 32'd0);

    // Test 1: EX add r3 feeds both operands.
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t1_fwdA", 32'(fa1), 32'd1);
    check("t1_fwdB", 32'(fb1), 32'd1);
    check("t1_stall", 32'(stall1), 32'd0);
    step();
    check("t1_fc1", 32'(fc1), 32'd1);
    check("t1_fc3", 32'(fc3), 32'd1);

    // Test 2: MEM beats WB; WB used once MEM stops writing; operand B follows src1 when selected.
    clear_inputs();
    EX_inst  = mk(3'd5, 3'd0, 3'd0); EX_reg_write_signal  = 1'b1;
    MEM_inst = mk(3'd2, 3'd0, 3'd0); MEM_reg_write_signal = 1'b1;
    WB_inst  = mk(3'd2, 3'd0, 3'd0); WB_reg_write_signal  = 1'b1;
    ID_inst  = mk(3'd1, 3'd2, 3'd7); ID_valid = 1'b1;
    #1;
    check("t2_fwdA_mem", 32'(fa1), 32'd2);
    check("t2_fwdB_none", 32'(fb1), 32'd0);
    MEM_reg_write_signal = 1'b0;
    #1;
    check("t2_fwdA_wb", 32'(fa1), 32'd3);
    ID_reg2_read_source = 1'b1;
    #1;
    check("t2_fwdB_src1", 32'(fb3), 32'd3);

    // Equal destinations in EX, MEM and WB pick EX.
    EX_inst = mk(3'd2, 3'd0, 3'd0); MEM_reg_write_signal = 1'b1;
    #1;
    check("prio_ex", 32'(fa1), 32'd1);

    // Test 3: r0 never forwards or stalls, even as a load target.
    clear_inputs();
    EX_inst = mk(3'd0, 3'd0, 3'd0); EX_reg_write_signal = 1'b1; EX_mem_read = 1'b1;
    MEM_reg_write_signal = 1'b1; WB_reg_write_signal = 1'b1;
    ID_inst = mk(3'd1, 3'd0, 3'd0); ID_valid = 1'b1;
    #1;
    check("t3_fwdA", 32'(fa1), 32'd0);
    check("t3_fwdB", 32'(fb1), 32'd0);
    check("t3_stall", 32'(stall1), 32'd0);

    // A load in EX falls through to MEM for forwarding while stalling.
    clear_inputs();
    EX_inst  = mk(3'd4, 3'd0, 3'd0); EX_reg_write_signal = 1'b1; EX_mem_read = 1'b1;
    MEM_inst = mk(3'd4, 3'd0, 3'd0); MEM_reg_write_signal = 1'b1;
    ID_inst  = mk(3'd1, 3'd4, 3'd0); ID_valid = 1'b1;
    #1;
    check("ld_fallthru", 32'(fa1), 32'd2);
    check("ld_fallthru_stall", 32'(stall1), 32'd1);

    // Test 6a: store data forwarded from MEM.
    clear_inputs();
    EX_inst  = mk(3'd1, 3'd2, 3'd0); EX_mem_write = 1'b1;
    MEM_inst = mk(3'd1, 3'd0, 3'd0); MEM_reg_write_signal = 1'b1;
    #1;
    check("t6_fmd_on", 32'(fmd1), 32'd1);
    MEM_inst = mk(3'd0, 3'd0, 3'd0);
    #1;
    check("t6_fmd_r0", 32'(fmd3), 32'd0);

    // Test 4: LOAD_STALL=1 stalls exactly one cycle, then MEM forwards.
    clear_inputs();
    pulse_reset();
    set_load_use();
    #1;
    check("t4_stall", 32'(stall1), 32'd1);
    check("t4_bubble", 32'(bubble1), 32'd1);
    step();
    check("t4_sc", 32'(sc1), 32'd1);
    set_after_load();
    #1;
    check("t4_stall_off", 32'(stall1), 32'd0);
    check("t4_fwdA", 32'(fa1), 32'd2);
    step();
    check("t4_fc", 32'(fc1), 32'd1);
    check("t4_sc_hold", 32'(sc1), 32'd1);

    // Test 5: LOAD_STALL=3 stalls exactly three cycles.
    clear_inputs();
    pulse_reset();
    set_load_use();
    #1;
    check("t5_c1_stall", 32'(stall3), 32'd1);
    step();
    set_after_load();
    #1;
    check("t5_c2_stall", 32'(stall3), 32'd1);
    check("t5_c2_bubble", 32'(bubble3), 32'd1);
    check("t5_c2_fwdA", 32'(fa3), 32'd2);
    check("t5_c2_sc", 32'(sc3), 32'd1);
    step();
    check("t5_c3_stall", 32'(stall3), 32'd1);
    check("t5_c3_sc", 32'(sc3), 32'd2);
    step();
    check("t5_end_stall", 32'(stall3), 32'd0);
    check("t5_end_sc", 32'(sc3), 32'd3);
    check("t5_end_fc", 32'(fc3), 32'd0);

    // Test 5b: reset during the second stall cycle abandons the stall.
    clear_inputs();
    pulse_reset();
    set_load_use();
    step();
    set_after_load();
    #1;
    check("t5b_hold", 32'(stall3), 32'd1);
    rst = 1'b1;
    #1;
    check("t5b_rst_stall", 32'(stall3), 32'd0);
    check("t5b_rst_bubble", 32'(bubble3), 32'd0);
    check("t5b_rst_sc", 32'(sc3), 32'd0);
    check("t5b_rst_fwdA", 32'(fa3), 32'd0);
    rst = 1'b0;
    #1;
    check("t5b_post_stall", 32'(stall3), 32'd0);
    check("t5b_post_fwdA", 32'(fa3), 32'd2);
    step();
    check("t5b_post_sc", 32'(sc3), 32'd0);

    // Test 6b: continuous load-use saturates stall_count.
    clear_inputs();
    pulse_reset();
    set_load_use();
    repeat (65538) @(posedge clk);
    #1;
    check("t6_sat_sc1", 32'(sc1), 32'hFFFF);
    check("t6_sat_sc3", 32'(sc3), 32'hFFFF);
    check("t6_sat_stall", 32'(stall1), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
